core_mem_arbiter: RTL and testbench
===================================

// Module: core_mem_arbiter
// PURPOSE
// - Shares one AXI4 master port between NUM_CORES single-word core memory ports (req/we/addr/wdata/ack).
// - Round-robin grant; one outstanding single-beat AXI transaction at a time.
// - Sits between the per-core data-memory ports and the cluster AXI4 data-memory master.
// PARAMETERS
// DATA_WIDTH      32  core/AXI data width; multiple of 8
// ADDR_WIDTH      32  core/AXI address width
// NUM_CORES       4   requesters, 2..16 (ID fits the 4-bit AXI ID)
// TIMEOUT_CYCLES  256 response watchdog limit; used only with CMA_TIMEOUT_EN
// PORTS
// clk            in   1                      single clock, rising edge
// rst            in   1                      synchronous, active-high reset
// core_req       in   NUM_CORES              per-core request; held until ack
// core_we        in   NUM_CORES              1=write, 0=read
// core_addr      in   NUM_CORES*ADDR_WIDTH   per-core address (packed, core i at slice i)
// core_wdata     in   NUM_CORES*DATA_WIDTH   per-core write data
// core_rdata     out  DATA_WIDTH             read data, broadcast, valid with ack
// core_ack       out  NUM_CORES              one-hot, one-cycle completion pulse
// core_err       out  1                      error qualifier, valid with any ack bit
// m_axi_aw*/w*/b*/ar*/r*  AXI4 master, 4-bit IDs, full signal set as on the cluster AXI ports
// BEHAVIOUR
// - Reset: FSM=IDLE, rr pointer=0, all valid/ready low, core_ack=0, core_err=0, core_rdata=0.
// - All AXI outputs are registered. Fixed fields: len=0, size=$clog2(DATA_WIDTH/8), burst=INCR, lock=0, cache=0, prot=0, wstrb=all ones, wlast=1, a*id=grant index.
// - Arbitration in IDLE only: first asserted core_req at or after the rr pointer, wrapping. Grant, addr, wdata, we are latched.
// - rr pointer = (grant+1) mod NUM_CORES on completion. Back-to-back: no core starves; worst-case wait is NUM_CORES-1 transactions.
// - FSM states:
//   - IDLE: any req -> RADDR if we=0, WADDR if we=1.
//   - RADDR: arvalid=1 until arready -> RDATA.
//   - RDATA: rready=1; rvalid -> ACK; latch rdata; err = (rresp!=OKAY).
//   - WADDR: awvalid and wvalid raised together; each drops independently after its own handshake; both done -> WRESP.
//   - WRESP: bready=1; bvalid -> ACK; err = (bresp!=OKAY).
//   - ACK: core_ack[grant]=1 and core_err for one cycle -> IDLE.
// - Latency, zero-wait slave (arready=1, rvalid the cycle after the AR handshake):
//   - read: req seen in IDLE cycle N -> arvalid N+1, rvalid N+2, ack N+3.
//   - Writes complete the same way.
// - Minimum issue interval is 4 cycles; IDLE always takes one cycle.
// - The core must see ack before it drops req. If req drops mid-transaction, the AXI transaction still completes and the ack still pulses.
// - Requests from other cores while busy are held off and considered in the next IDLE.
// - rid/bid are not checked (single outstanding transaction).
// - Reset mid-transaction returns to IDLE immediately and drops valid/ready. The system resets the AXI slave with it.
// - Write-path ready signals (awready, wready) are valid in any order and cycle, including both in the first cycle.
// CONFIGURATION
// - CMA_TIMEOUT_EN defined:
//   - A counter runs in RDATA and WRESP.
//   - When it reaches TIMEOUT_CYCLES, the block enters DRAIN and pulses ack with core_err=1 for the granted core. core_rdata is 0 for a timed-out read.
//   - DRAIN holds rready/bready high until the late response arrives, then goes to IDLE.
//   - New grants are blocked during DRAIN. The counter clears on each state entry.
// - CMA_TIMEOUT_EN undefined: no counter or DRAIN state; the block waits indefinitely. core_err reflects only resp.
// TESTING
// - Single read, core 2, addr 0x100, zero-wait slave, rdata 0xDEADBEEF -> arid=2, araddr=0x100, ack=4'b0100 at N+3, rdata=0xDEADBEEF, err=0.
// - All 4 cores assert reads together, each held until its ack -> grants in order 0,1,2,3. A repeat from core 0 is served after core 3.
// - Write, core 1, 0x2000 <= 0x12345678:
//   - Run 1: awready in cycle 1, wready 3 cycles later.
//   - Run 2: wready first, then awready.
//   - Both runs -> exactly one AW and one W handshake, wstrb=0xF, wlast=1, then bready, then ack[1].
// - Read with rresp=SLVERR -> ack with core_err=1. Next transaction returns err=0.
// - rst asserted while in WRESP -> next cycle all valid/ready=0, no ack. A fresh request is served normally after reset.
// - CMA_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never sends rvalid -> ack+err after 16 cycles in RDATA. Later rvalid is drained; other grants are blocked until then.

Source files
------------

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter
// Shares one AXI4 master port between NUM_CORES single-word core memory ports.
// Round-robin grant, one single-beat AXI transaction outstanding at a time.
// Optional response watchdog with drain state: define CMA_TIMEOUT_EN.
module core_mem_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_CORES      = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  // core side
  input  logic [NUM_CORES-1:0]             core_req,
  input  logic [NUM_CORES-1:0]             core_we,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0]  core_addr,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]  core_wdata,
  output logic [DATA_WIDTH-1:0]            core_rdata,
  output logic [NUM_CORES-1:0]             core_ack,
  output logic                             core_err,
  // AXI write address
  output logic [3:0]                       m_axi_awid,
  output logic [ADDR_WIDTH-1:0]            m_axi_awaddr,
  output logic [7:0]                       m_axi_awlen,
  output logic [2:0]                       m_axi_awsize,
  output logic [1:0]                       m_axi_awburst,
  output logic                             m_axi_awlock,
  output logic [3:0]                       m_axi_awcache,
  output logic [2:0]                       m_axi_awprot,
  output logic [3:0]                       m_axi_awqos,
  output logic                             m_axi_awvalid,
  input  logic                             m_axi_awready,
  // AXI write data
  output logic [DATA_WIDTH-1:0]            m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]          m_axi_wstrb,
  output logic                             m_axi_wlast,
  output logic                             m_axi_wvalid,
  input  logic                             m_axi_wready,
  // AXI write response
  input  logic [3:0]                       m_axi_bid,
  input  logic [1:0]                       m_axi_bresp,
  input  logic                             m_axi_bvalid,
  output logic                             m_axi_bready,
  // AXI read address
  output logic [3:0]                       m_axi_arid,
  output logic [ADDR_WIDTH-1:0]            m_axi_araddr,
  output logic [7:0]                       m_axi_arlen,
  output logic [2:0]                       m_axi_arsize,
  output logic [1:0]                       m_axi_arburst,
  output logic                             m_axi_arlock,
  output logic [3:0]                       m_axi_arcache,
  output logic [2:0]                       m_axi_arprot,
  output logic [3:0]                       m_axi_arqos,
  output logic                             m_axi_arvalid,
  input  logic                             m_axi_arready,
  // AXI read data
  input  logic [3:0]                       m_axi_rid,
  input  logic [DATA_WIDTH-1:0]            m_axi_rdata,
  input  logic [1:0]                       m_axi_rresp,
  input  logic                             m_axi_rlast,
  input  logic                             m_axi_rvalid,
  output logic                             m_axi_rready
);

  localparam int IDX_W = $clog2(NUM_CORES);
  localparam int SIZE  = $clog2(DATA_WIDTH/8);
  localparam logic [IDX_W:0]   NUM_W    = (IDX_W+1)'(NUM_CORES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORES-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WADDR,
    S_WRESP,
`ifdef CMA_TIMEOUT_EN
    S_DRAIN,
`endif
    S_ACK
  } state_t;

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        rr_reg, rr_next;
  logic [IDX_W-1:0]        grant_reg, grant_next;
  logic                    we_reg, we_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic                    arvalid_reg, arvalid_next;
  logic                    rready_reg, rready_next;
  logic                    awvalid_reg, awvalid_next;
  logic                    wvalid_reg, wvalid_next;
  logic                    bready_reg, bready_next;
  logic [NUM_CORES-1:0]    ack_reg, ack_next;
  logic                    err_reg, err_next;
  logic [DATA_WIDTH-1:0]   rdata_reg, rdata_next;

  logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_CORES];
  logic [DATA_WIDTH-1:0]   wdata_arr [NUM_CORES];
  logic                    req_any;
  logic [IDX_W-1:0]        pick;
  logic [IDX_W:0]          sum;
  logic [NUM_CORES-1:0]    grant_onehot;
  logic                    aw_done, w_done;
  logic                    timer_expired;

  // Response IDs and rlast carry no information with a single outstanding beat.
  logic unused_inputs;
  assign unused_inputs = ^{m_axi_bid, m_axi_rid, m_axi_rlast};

  // Unpack the per-core address/data buses into arrays indexed by core.
  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_unpack
    assign addr_arr[gi]  = core_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi] = core_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search: first requester at or after rr_reg, wrapping.
  always_comb begin
    req_any = 1'b0;
    pick    = '0;
    sum     = '0;
    for (int off = 0; off < NUM_CORES; off++) begin
      sum = {1'b0, rr_reg} + (IDX_W+1)'(off);
      if (sum >= NUM_W) sum = sum - NUM_W;
      if (!req_any && core_req[sum[IDX_W-1:0]]) begin
        req_any = 1'b1;
        pick    = sum[IDX_W-1:0];
      end
    end
  end

  assign grant_onehot = NUM_CORES'(1) << grant_reg;
  assign aw_done      = !awvalid_reg || m_axi_awready;
  assign w_done       = !wvalid_reg  || m_axi_wready;

`ifdef CMA_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES+1);
  logic [TMR_W-1:0] timer_reg;

  assign timer_expired = (timer_reg == TMR_W'(TIMEOUT_CYCLES-1));

  // Response watchdog: counts cycles in RDATA/WRESP, cleared on every state change.
  always_ff @(posedge clk) begin
    if (rst || (state_next != state_reg)) begin
      timer_reg <= '0;
    end else if ((state_reg == S_RDATA) || (state_reg == S_WRESP)) begin
      timer_reg <= timer_reg + TMR_W'(1);
    end
  end
`else
  assign timer_expired = 1'b0;
`endif

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_next   = state_reg;
    rr_next      = rr_reg;
    grant_next   = grant_reg;
    we_next      = we_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    arvalid_next = arvalid_reg;
    rready_next  = rready_reg;
    awvalid_next = awvalid_reg;
    wvalid_next  = wvalid_reg;
    bready_next  = bready_reg;
    ack_next     = '0;
    err_next     = 1'b0;
    rdata_next   = rdata_reg;

    case (state_reg)
      S_IDLE: begin
        if (req_any) begin
          grant_next = pick;
          we_next    = core_we[pick];
          addr_next  = addr_arr[pick];
          wdata_next = wdata_arr[pick];
          if (core_we[pick]) begin
            state_next   = S_WADDR;
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
          end else begin
            state_next   = S_RADDR;
            arvalid_next = 1'b1;
          end
        end
      end
      S_RADDR: begin
        if (m_axi_arready) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          state_next   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (m_axi_rvalid) begin
          rready_next = 1'b0;
          rdata_next  = m_axi_rdata;
          err_next    = (m_axi_rresp != 2'b00);
          ack_next    = grant_onehot;
          state_next  = S_ACK;
        end
`ifdef CMA_TIMEOUT_EN
        else if (timer_expired) begin
          // rready stays high so the late beat is consumed in DRAIN
          rdata_next = '0;
          err_next   = 1'b1;
          ack_next   = grant_onehot;
          state_next = S_DRAIN;
        end
`endif
      end
      S_WADDR: begin
        // AW and W drop independently after their own handshakes
        awvalid_next = awvalid_reg && !m_axi_awready;
        wvalid_next  = wvalid_reg  && !m_axi_wready;
        if (aw_done && w_done) begin
          bready_next = 1'b1;
          state_next  = S_WRESP;
        end
      end
      S_WRESP: begin
        if (m_axi_bvalid) begin
          bready_next = 1'b0;
          err_next    = (m_axi_bresp != 2'b00);
          ack_next    = grant_onehot;
          state_next  = S_ACK;
        end
`ifdef CMA_TIMEOUT_EN
        else if (timer_expired) begin
          err_next   = 1'b1;
          ack_next   = grant_onehot;
          state_next = S_DRAIN;
        end
`endif
      end
`ifdef CMA_TIMEOUT_EN
      S_DRAIN: begin
        if (we_reg ? m_axi_bvalid : m_axi_rvalid) begin
          rready_next = 1'b0;
          bready_next = 1'b0;
          state_next  = S_IDLE;
        end
      end
`endif
      S_ACK: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Advance the round-robin pointer past the core just completed
    if (|ack_next) rr_next = (grant_reg == LAST_IDX) ? '0 : grant_reg + IDX_W'(1);
  end

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      rr_reg      <= '0;
      grant_reg   <= '0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      arvalid_reg <= 1'b0;
      rready_reg  <= 1'b0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      bready_reg  <= 1'b0;
      ack_reg     <= '0;
      err_reg     <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      rr_reg      <= rr_next;
      grant_reg   <= grant_next;
      we_reg      <= we_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      arvalid_reg <= arvalid_next;
      rready_reg  <= rready_next;
      awvalid_reg <= awvalid_next;
      wvalid_reg  <= wvalid_next;
      bready_reg  <= bready_next;
      ack_reg     <= ack_next;
      err_reg     <= err_next;
      rdata_reg   <= rdata_next;
    end
  end

  assign core_ack      = ack_reg;
  assign core_err      = err_reg;
  assign core_rdata    = rdata_reg;

  assign m_axi_awid    = 4'(grant_reg);
  assign m_axi_awaddr  = addr_reg;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_awvalid = awvalid_reg;

  assign m_axi_wdata   = wdata_reg;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_wvalid  = wvalid_reg;
  assign m_axi_bready  = bready_reg;

  assign m_axi_arid    = 4'(grant_reg);
  assign m_axi_araddr  = addr_reg;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arqos   = 4'd0;
  assign m_axi_arvalid = arvalid_reg;
  assign m_axi_rready  = rready_reg;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed testbench for core_mem_arbiter (4 cores, 32-bit data/address).
module tb_core_mem_arbiter;
  localparam int NC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [NC-1:0] core_req, core_we, core_ack;
  logic [NC*32-1:0] core_addr, core_wdata;
  logic [31:0] core_rdata;
  logic core_err;
  logic [3:0] awid, arid, awcache, arcache, awqos, arqos, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awlock, arlock, awvalid, awready, wvalid, wready, wlast;
  logic [3:0] wstrb;
  logic bvalid, bready, arvalid, arready, rvalid, rready, rlast;

  int checks = 0;
  int errors = 0;

  core_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_CORES(NC), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_ack(core_ack), .core_err(core_err),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache), .m_axi_awprot(awprot),
    .m_axi_awqos(awqos), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache), .m_axi_arprot(arprot),
    .m_axi_arqos(arqos), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Stimulus helper: issue one read from a core against a zero-wait slave, record results.
  task automatic run_read(input int core, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] resp, output int ack_cyc, output logic [3:0] ack_val,
                          output logic [31:0] rd, output logic err, output logic [3:0] arid_seen);
    logic hs_prev;
    hs_prev = 1'b0;
    ack_cyc = -1; ack_val = '0; rd = '0; err = 1'b0; arid_seen = 4'hF;
    core_we[core] = 1'b0;
    core_addr[core*32 +: 32] = addr;
    core_req[core] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick;
      rvalid = hs_prev;
      rdata  = hs_prev ? data : 32'h0;
      rresp  = hs_prev ? resp : 2'b00;
      hs_prev = arvalid && arready;
      if (hs_prev) arid_seen = arid;
      if (|core_ack) begin
        ack_cyc = c; ack_val = core_ack; rd = core_rdata; err = core_err;
        core_req[core] = 1'b0;
        break;
      end
    end
    core_req[core] = 1'b0;
    rvalid = 1'b0;
    $display("read core %0d addr %h rdata %h resp %0d err %0b ack_cycle %0d", core, addr, rd, resp, err, ack_cyc);
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick;
    checks++;
    if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin
      errors++; $display("FAIL reset_valid_ready: got %b expected 00000", {arvalid, awvalid, wvalid, rready, bready});
    end
    checks++;
    if ({core_ack, core_err} !== 5'b0) begin
      errors++; $display("FAIL reset_ack_err: got %b expected 00000", {core_ack, core_err});
    end
    checks++;
    if (core_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h expected 0", core_rdata);
    end
    rst = 1'b0;
    tick;
    checks++;
    if ({arvalid, awvalid, core_ack} !== 6'b0) begin
      errors++; $display("FAIL reset_idle_quiet: got %b expected 000000", {arvalid, awvalid, core_ack});
    end
    $display("reset released");
  endtask

  task automatic test_round_robin;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int grants[$];
    int acks[$];
    logic hs_prev, reassert, repeated;
    logic [3:0] hs_id;
    int idx;
    hs_prev = 1'b0; reassert = 1'b0; repeated = 1'b0; hs_id = '0;
    for (int i = 0; i < NC; i++) begin
      core_we[i] = 1'b0;
      core_addr[i*32 +: 32] = 32'h1000 + 32'(4*i);
    end
    core_req = 4'hF;
    for (int c = 1; c <= 60; c++) begin
      tick;
      if (reassert) begin core_req[0] = 1'b1; reassert = 1'b0; end
      rvalid = hs_prev;
      rdata  = hs_prev ? (32'hA000_0000 + 32'(hs_id)) : 32'h0;
      rresp  = 2'b00;
      hs_prev = arvalid && arready;
      if (hs_prev) begin hs_id = arid; grants.push_back(int'(arid)); end
      if (|core_ack) begin
        idx = -1;
        for (int i = 0; i < NC; i++) if (core_ack[i]) idx = i;
        acks.push_back(idx);
        $display("rr read ack core %0d rdata %h", idx, core_rdata);
        checks++;
        if (core_rdata !== 32'hA000_0000 + 32'(idx)) begin
          errors++; $display("FAIL rr_rdata core %0d: got %h expected %h", idx, core_rdata, 32'hA000_0000 + 32'(idx));
        end
        if (idx >= 0) core_req[idx] = 1'b0;
        if (idx == 0 && !repeated) begin reassert = 1'b1; repeated = 1'b1; end
      end
      if (acks.size() == 5) break;
    end
    rvalid = 1'b0;
    core_req = '0;
    tick;
    checks++;
    if (acks.size() != 5 || grants.size() != 5) begin
      errors++; $display("FAIL rr_count: got %0d acks %0d grants expected 5", acks.size(), grants.size());
    end
    for (int i = 0; i < 5 && i < acks.size() && i < grants.size(); i++) begin
      checks++;
      if (grants[i] != exp_order[i] || acks[i] != exp_order[i]) begin
        errors++; $display("FAIL rr_order[%0d]: got grant %0d ack %0d expected %0d", i, grants[i], acks[i], exp_order[i]);
      end
    end
  endtask

  task automatic test_single_read;
    core_we[2] = 1'b0;
    core_addr[64 +: 32] = 32'h100;
    core_req[2] = 1'b1;
    tick;  // N+1
    checks++;
    if ({arvalid, arid, araddr} !== {1'b1, 4'd2, 32'h100}) begin
      errors++; $display("FAIL read_ar: got valid %b id %0d addr %h expected 1 2 00000100", arvalid, arid, araddr);
    end
    checks++;
    if ({arlen, arsize, arburst, arlock, arcache, arprot, arqos} !== {8'd0, 3'd2, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0}) begin
      errors++; $display("FAIL read_ar_fields: got len %0d size %0d burst %0d", arlen, arsize, arburst);
    end
    tick;  // N+2
    checks++;
    if ({arvalid, rready, core_ack} !== 6'b010000) begin
      errors++; $display("FAIL read_rdata_phase: got %b expected 010000", {arvalid, rready, core_ack});
    end
    rvalid = 1'b1; rdata = 32'hDEADBEEF; rresp = 2'b00;
    tick;  // N+3
    rvalid = 1'b0; rdata = 32'h0;
    checks++;
    if ({core_ack, core_err, core_rdata} !== {4'b0100, 1'b0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL read_ack: got ack %b err %b rdata %h expected 0100 0 deadbeef", core_ack, core_err, core_rdata);
    end
    core_req[2] = 1'b0;
    $display("read core 2 addr 00000100 rdata %h err %0b", core_rdata, core_err);
    tick;
    checks++;
    if (core_ack !== 4'b0) begin
      errors++; $display("FAIL read_ack_pulse: got %b expected 0000", core_ack);
    end
  endtask

  // run 1: awready first, wready 3 cycles later; run 2: wready first, then awready
  task automatic test_write(input int run);
    int aw_hs, w_hs, bready_cyc, exp_bready;
    aw_hs = 0; w_hs = 0; bready_cyc = -1;
    exp_bready = (run == 1) ? 5 : 4;
    core_we[1] = 1'b1;
    core_addr[32 +: 32] = 32'h2000;
    core_wdata[32 +: 32] = 32'h12345678;
    core_req[1] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick;
      if (run == 1) begin awready = (k >= 1); wready = (k >= 4); end
      else begin wready = (k >= 1); awready = (k >= 3); end
      if (k == 1) begin
        checks++;
        if ({awvalid, wvalid, awid, awaddr, wdata} !== {2'b11, 4'd1, 32'h2000, 32'h12345678}) begin
          errors++; $display("FAIL write%0d_addr_data: got v %b%b id %0d addr %h data %h", run, awvalid, wvalid, awid, awaddr, wdata);
        end
        checks++;
        if ({wstrb, wlast, awlen, awsize, awburst, awlock, awcache, awprot, awqos} !== {4'hF, 1'b1, 8'd0, 3'd2, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0}) begin
          errors++; $display("FAIL write%0d_fields: got strb %h last %b len %0d size %0d burst %0d", run, wstrb, wlast, awlen, awsize, awburst);
        end
      end
      if (awvalid && awready) aw_hs++;
      if (wvalid && wready) w_hs++;
      if (bready) begin bready_cyc = k; break; end
    end
    awready = 1'b0; wready = 1'b0;
    bvalid = 1'b1; bresp = 2'b00;
    checks++;
    if (bready_cyc != exp_bready || aw_hs != 1 || w_hs != 1) begin
      errors++; $display("FAIL write%0d_handshakes: got bready cycle %0d aw %0d w %0d expected %0d 1 1", run, bready_cyc, aw_hs, w_hs, exp_bready);
    end
    tick;
    bvalid = 1'b0;
    checks++;
    if ({core_ack, core_err} !== {4'b0010, 1'b0}) begin
      errors++; $display("FAIL write%0d_ack: got ack %b err %b expected 0010 0", run, core_ack, core_err);
    end
    core_req[1] = 1'b0;
    core_we[1] = 1'b0;
    $display("write run %0d core 1 addr 00002000 data 12345678 ack %b", run, core_ack);
    tick;
    checks++;
    if (core_ack !== 4'b0) begin
      errors++; $display("FAIL write%0d_ack_pulse: got %b expected 0000", run, core_ack);
    end
  endtask

  task automatic test_error;
    int ac; logic [3:0] av; logic [31:0] rd; logic er; logic [3:0] id;
    run_read(3, 32'h300, 32'hBAD0BAD0, 2'b10, ac, av, rd, er, id);
    checks++;
    if ({ac == 3, av, er, id} !== {1'b1, 4'b1000, 1'b1, 4'd3}) begin
      errors++; $display("FAIL err_slverr: got cycle %0d ack %b err %b id %0d expected 3 1000 1 3", ac, av, er, id);
    end
    run_read(0, 32'h0, 32'h55AA55AA, 2'b00, ac, av, rd, er, id);
    checks++;
    if ({av, er, rd} !== {4'b0001, 1'b0, 32'h55AA55AA}) begin
      errors++; $display("FAIL err_next_ok: got ack %b err %b rdata %h expected 0001 0 55aa55aa", av, er, rd);
    end
  endtask

  task automatic test_reset_mid;
    int ac; logic [3:0] av; logic [31:0] rd; logic er; logic [3:0] id;
    logic seen_ack;
    core_we[2] = 1'b1;
    core_addr[64 +: 32] = 32'h40;
    core_wdata[64 +: 32] = 32'h0BADF00D;
    core_req[2] = 1'b1;
    tick;  // WADDR
    awready = 1'b1; wready = 1'b1;
    tick;  // WRESP
    awready = 1'b0; wready = 1'b0;
    checks++;
    if (bready !== 1'b1) begin
      errors++; $display("FAIL rstmid_in_wresp: got bready %b expected 1", bready);
    end
    rst = 1'b1;
    core_req[2] = 1'b0;
    core_we[2] = 1'b0;
    tick;
    checks++;
    if ({arvalid, awvalid, wvalid, rready, bready, core_ack, core_err} !== 10'b0) begin
      errors++; $display("FAIL rstmid_quiet: got %b expected 0000000000", {arvalid, awvalid, wvalid, rready, bready, core_ack, core_err});
    end
    checks++;
    if (core_rdata !== 32'h0) begin
      errors++; $display("FAIL rstmid_rdata: got %h expected 0", core_rdata);
    end
    rst = 1'b0;
    seen_ack = 1'b0;
    repeat (3) begin
      tick;
      if (|core_ack) seen_ack = 1'b1;
    end
    checks++;
    if (seen_ack !== 1'b0) begin
      errors++; $display("FAIL rstmid_no_ack: got ack after reset expected none");
    end
    $display("reset asserted during write response, block idle");
    run_read(1, 32'h500, 32'hCAFEF00D, 2'b00, ac, av, rd, er, id);
    checks++;
    if ({ac == 3, av, er, rd, id} !== {1'b1, 4'b0010, 1'b0, 32'hCAFEF00D, 4'd1}) begin
      errors++; $display("FAIL rstmid_fresh_read: got cycle %0d ack %b err %b rdata %h id %0d", ac, av, er, rd, id);
    end
  endtask

`ifdef CMA_TIMEOUT_EN
  task automatic test_timeout;
    int ack_c, ar_c;
    logic [3:0] av; logic er, saw_ar, rr_low, hs_prev; logic [31:0] rd;
    ack_c = -1; av = '0; er = 1'b0; rd = 32'hFFFF_FFFF;
    core_we[0] = 1'b0;
    core_addr[0 +: 32] = 32'h80;
    core_req[0] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick;
      if (|core_ack) begin ack_c = c; av = core_ack; er = core_err; rd = core_rdata; break; end
    end
    core_req[0] = 1'b0;
    checks++;
    if ({ack_c == 18, av, er, rd} !== {1'b1, 4'b0001, 1'b1, 32'h0}) begin
      errors++; $display("FAIL timeout_ack: got cycle %0d ack %b err %b rdata %h expected 18 0001 1 0", ack_c, av, er, rd);
    end
    $display("timeout read core 0 ack_cycle %0d err %0b", ack_c, er);
    core_we[1] = 1'b0;
    core_addr[32 +: 32] = 32'h44;
    core_req[1] = 1'b1;
    saw_ar = 1'b0; rr_low = 1'b0;
    repeat (6) begin
      tick;
      if (arvalid) saw_ar = 1'b1;
      if (!rready) rr_low = 1'b1;
    end
    checks++;
    if ({saw_ar, rr_low} !== 2'b00) begin
      errors++; $display("FAIL timeout_drain_block: got ar %b rready_low %b expected 0 0", saw_ar, rr_low);
    end
    rvalid = 1'b1; rdata = 32'h11111111; rresp = 2'b00;
    ar_c = -1;
    for (int c = 1; c <= 10; c++) begin
      tick;
      rvalid = 1'b0; rdata = 32'h0;
      if (arvalid) begin ar_c = c; break; end
    end
    checks++;
    if (ar_c != 2 || arid !== 4'd1) begin
      errors++; $display("FAIL timeout_next_grant: got cycle %0d id %0d expected 2 1", ar_c, arid);
    end
    hs_prev = arvalid && arready;
    ack_c = -1; av = '0; er = 1'b1; rd = '0;
    for (int c = 1; c <= 10; c++) begin
      tick;
      rvalid = hs_prev; rdata = hs_prev ? 32'h44444444 : 32'h0;
      hs_prev = 1'b0;
      if (|core_ack) begin ack_c = c; av = core_ack; er = core_err; rd = core_rdata; break; end
    end
    core_req[1] = 1'b0;
    rvalid = 1'b0;
    checks++;
    if ({av, er, rd} !== {4'b0010, 1'b0, 32'h44444444}) begin
      errors++; $display("FAIL timeout_after_drain: got ack %b err %b rdata %h expected 0010 0 44444444", av, er, rd);
    end
    $display("read core 1 after drain rdata %h err %0b", rd, er);
    tick;
  endtask
`endif

  initial begin
    rst = 1'b1;
    core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 4'd0;
    arready = 1'b1; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00; rid = 4'd0; rlast = 1'b1;
    test_reset;
    test_round_robin;
    test_single_read;
    test_write(1);
    test_write(2);
    test_error;
    test_reset_mid;
`ifdef CMA_TIMEOUT_EN
    test_timeout;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "time limit");
  end

endmodule
